// File: rtl/instr_fetch.sv
// Instruction fetch front end: drives a 1-cycle-latency instruction memory,
// buffers returned words in a small FIFO and hands them, tagged with their
// word address, to the decode stage over a valid/ready handshake.
module instr_fetch #(
    parameter int                    WIDTH_DATA = 32,
    parameter int                    WIDTH_ADDR = 16,
    parameter logic [WIDTH_ADDR-1:0] RESET_ADDR = '0,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_re,
    output logic [WIDTH_ADDR-1:0] mem_addr,
    input  logic [WIDTH_DATA-1:0] mem_data,
    input  logic                  redirect_valid,
    input  logic [WIDTH_ADDR-1:0] redirect_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH_DATA-1:0] out_instr,
    output logic [WIDTH_ADDR-1:0] out_addr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W:0]   DEPTH_CREDIT = (CNT_W + 1)'(FIFO_DEPTH);

    logic [WIDTH_ADDR-1:0] pc;
    logic                  inflight;
    logic [WIDTH_ADDR-1:0] tag_addr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [WIDTH_DATA-1:0] fifo_instr [FIFO_DEPTH];
    logic [WIDTH_ADDR-1:0] fifo_addr  [FIFO_DEPTH];

    logic [CNT_W:0] credit_used;
    logic           push;
    logic           pop;

    // Issue, push and pop decisions for this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        credit_used = '0;
        mem_re      = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        // Credit counts buffered plus in-flight words but ignores this
        // cycle's pop, keeping out_ready off the mem_re path.
        credit_used = {1'b0, count} + (CNT_W + 1)'(inflight);
        mem_re      = !rst && !redirect_valid && (credit_used < DEPTH_CREDIT);
        push        = inflight && !rst && !redirect_valid;
        pop         = out_valid && out_ready && !rst && !redirect_valid;
    end

    assign mem_addr  = pc;
    assign out_valid = (count != '0);
    assign out_instr = fifo_instr[rd_ptr];
    assign out_addr  = fifo_addr[rd_ptr];

    // Control state: PC, request tag pipe, FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            pc       <= RESET_ADDR;
            inflight <= 1'b0;
            tag_addr <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            // Flush: the in-flight return and all buffered words are dropped.
            pc       <= redirect_addr;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (mem_re) begin
                pc       <= pc + 1'b1;
                inflight <= 1'b1;
                tag_addr <= pc;
            end else begin
                inflight <= 1'b0;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: returned word and its tag address land at the write pointer.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; count gates visibility, so
        // stale contents are never presented.
        if (push) begin
            fifo_instr[wr_ptr] <= mem_data;
            fifo_addr[wr_ptr]  <= tag_addr;
        end
    end

    // Credit must make a push into a full buffer impossible.
    push_never_full: assert property (
        @(posedge clk) disable iff (rst) push |-> (count != DEPTH_CNT)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, hand-written
// stall/reset sequences and a randomized run against an address-stream model.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        mem_re;
    logic [15:0] mem_addr;
    logic [31:0] mem_data;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [15:0] out_addr;

    int checks = 0;
    int errors = 0;

    instr_fetch #(
        .WIDTH_DATA(32),
        .WIDTH_ADDR(16),
        .RESET_ADDR(16'h0000),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem_re(mem_re),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_addr(out_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: mem[a] = 0xA000_0000 + a, registered read, 0 when idle.
    always @(posedge clk) begin
        mem_data <= mem_re ? (32'hA000_0000 + {16'h0000, mem_addr}) : 32'h0;
    end

    function automatic logic [31:0] word_at(input logic [15:0] a);
        return 32'hA000_0000 + {16'h0000, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: inputs change on the falling edge, outputs sampled 1 ns later.
    task automatic drive(input logic r, input logic rv, input logic [15:0] ra, input logic rdy);
        @(negedge clk);
        rst            = r;
        redirect_valid = rv;
        redirect_addr  = ra;
        out_ready      = rdy;
        #1;
    endtask

    typedef struct packed {
        logic        rst;
        logic        rv;
        logic [15:0] raddr;
        logic        ready;
        logic        exp_re;
        logic        exp_ov;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic rv, input logic [15:0] ra,
                       input logic re, input logic ov, input logic [15:0] a);
        vecs.push_back('{rst: r, rv: rv, raddr: ra, ready: 1'b1,
                         exp_re: re, exp_ov: ov, exp_addr: a});
    endtask

    initial begin
        logic [15:0] exp_next;
        int          issues;
        int          pops;
        int          gap;

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        out_ready      = 1'b0;

        // ---- Table: streaming, redirects, wrap, back-to-back redirects ----
        add(1, 0, 16'h0000, 0, 0, 16'h0000);
        add(1, 0, 16'h0000, 0, 0, 16'h0000);
        add(0, 0, 16'h0000, 1, 0, 16'h0000);   // cycle 0: first issue
        add(0, 0, 16'h0000, 1, 0, 16'h0000);   // cycle 1
        add(0, 0, 16'h0000, 1, 1, 16'h0000);   // cycle 2: first word
        add(0, 0, 16'h0000, 1, 1, 16'h0001);
        add(0, 0, 16'h0000, 1, 1, 16'h0002);
        add(0, 1, 16'h0100, 0, 1, 16'h0003);   // cycle 5: redirect, pop void
        add(0, 0, 16'h0000, 1, 0, 16'h0000);
        add(0, 0, 16'h0000, 1, 0, 16'h0000);
        add(0, 0, 16'h0000, 1, 1, 16'h0100);   // cycle 8
        add(0, 0, 16'h0000, 1, 1, 16'h0101);
        add(0, 1, 16'hFFFE, 0, 1, 16'h0102);   // redirect near wrap
        add(0, 0, 16'h0000, 1, 0, 16'h0000);
        add(0, 0, 16'h0000, 1, 0, 16'h0000);
        add(0, 0, 16'h0000, 1, 1, 16'hFFFE);
        add(0, 0, 16'h0000, 1, 1, 16'hFFFF);
        add(0, 0, 16'h0000, 1, 1, 16'h0000);
        add(0, 0, 16'h0000, 1, 1, 16'h0001);
        add(0, 1, 16'h0010, 0, 1, 16'h0002);   // back-to-back redirects
        add(0, 1, 16'h0020, 0, 0, 16'h0000);
        add(0, 0, 16'h0000, 1, 0, 16'h0000);
        add(0, 0, 16'h0000, 1, 0, 16'h0000);
        add(0, 0, 16'h0000, 1, 1, 16'h0020);
        add(0, 0, 16'h0000, 1, 1, 16'h0021);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].rv, vecs[i].raddr, vecs[i].ready);
            check($sformatf("vec%0d_mem_re", i), mem_re, vecs[i].exp_re);
            check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_ov);
            if (vecs[i].exp_ov) begin
                check($sformatf("vec%0d_out_addr", i), out_addr, vecs[i].exp_addr);
                check($sformatf("vec%0d_out_instr", i), out_instr, word_at(vecs[i].exp_addr));
            end
        end

        // ---- Stall from reset: buffer fills to 4, issue stops ----
        drive(1, 0, 16'h0, 0);
        drive(1, 0, 16'h0, 0);
        issues = 0;
        for (int c = 0; c < 10; c++) begin
            drive(0, 0, 16'h0, 0);
            if (mem_re) issues++;
            if (c >= 4) check($sformatf("stall_c%0d_mem_re", c), mem_re, 1'b0);
        end
        check("stall_issue_count", issues, 4);
        check("stall_out_valid", out_valid, 1'b1);
        check("stall_head_addr", out_addr, 16'h0000);
        // Release: addresses 0,1,2,... with no gap or duplicate.
        exp_next = 16'h0000;
        pops = 0;
        for (int c = 0; c < 10; c++) begin
            drive(0, 0, 16'h0, 1);
            if (out_valid) begin
                check("drain_addr", out_addr, exp_next);
                check("drain_instr", out_instr, word_at(exp_next));
                exp_next++;
                pops++;
            end
        end
        check("drain_pop_count", pops, 10);

        // ---- Reset mid-stream: 3 buffered words plus one in flight ----
        drive(0, 1, 16'h0050, 0);
        for (int c = 0; c < 4; c++) drive(0, 0, 16'h0, 0);
        drive(0, 0, 16'h0, 0);
        check("midrst_pre_mem_re", mem_re, 1'b0);
        check("midrst_pre_valid", out_valid, 1'b1);
        check("midrst_pre_addr", out_addr, 16'h0050);
        drive(1, 0, 16'h0, 0);
        check("midrst_rst_mem_re", mem_re, 1'b0);
        drive(0, 0, 16'h0, 1);
        check("midrst_c0_valid", out_valid, 1'b0);
        check("midrst_c0_mem_re", mem_re, 1'b1);
        drive(0, 0, 16'h0, 1);
        check("midrst_c1_valid", out_valid, 1'b0);
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 16'h0, 1);
            check($sformatf("midrst_c%0d_valid", c + 2), out_valid, 1'b1);
            check($sformatf("midrst_c%0d_addr", c + 2), out_addr, 16'(c));
            check($sformatf("midrst_c%0d_instr", c + 2), out_instr, word_at(16'(c)));
        end

        // ---- Randomized run against an in-order address-stream model ----
        // Model: after reset the stream is RESET_ADDR, +1, ...; after a
        // redirect it is redirect_addr, +1, ...; every accepted word must be
        // the next one in the stream, and valid never drops for more than the
        // two-cycle refill after a reset or redirect.
        drive(1, 0, 16'h0, 0);
        exp_next = 16'h0000;
        gap = 0;
        for (int c = 0; c < 3000; c++) begin
            logic        r_rst;
            logic        r_rv;
            logic [15:0] r_addr;
            logic        r_rdy;
            r_rst  = ($urandom_range(0, 199) == 0);
            r_rv   = !r_rst && ($urandom_range(0, 29) == 0);
            r_addr = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                                 : 16'($urandom);
            r_rdy  = ($urandom_range(0, 9) < 7);
            drive(r_rst, r_rv, r_addr, r_rdy);
            if (r_rst) begin
                check("rand_rst_mem_re", mem_re, 1'b0);
                exp_next = 16'h0000;
                gap = 0;
            end else if (r_rv) begin
                check("rand_redirect_mem_re", mem_re, 1'b0);
                exp_next = r_addr;
                gap = 0;
            end else if (out_valid) begin
                gap = 0;
                if (r_rdy) begin
                    check("rand_addr", out_addr, exp_next);
                    check("rand_instr", out_instr, word_at(exp_next));
                    exp_next++;
                end
            end else begin
                gap++;
                check("rand_bubble_len_ok", (gap <= 2), 1'b1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch front end that drives a synchronous read-only instruction memory (1-cycle read latency; read data is 0 when the read enable is low).
- Holds a word-address program counter and issues one read per cycle while buffer credit remains.
- Captures returned words into a small FIFO and presents them with their addresses to the decode stage over a valid/ready handshake.
- Supports redirect (branch/jump): the PC is reloaded and all fetched and in-flight words are flushed.

Parameters:
- WIDTH_DATA, 32, instruction word width; must match the memory data width.
- WIDTH_ADDR, 16, word address width; must match the memory address width.
- RESET_ADDR, 0, PC value after reset (WIDTH_ADDR bits).
- FIFO_DEPTH, 4, output buffer entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- mem_re  out  1  memory read enable.
- mem_addr  out  WIDTH_ADDR  memory word address.
- mem_data  in  WIDTH_DATA  memory read data, valid the cycle after mem_re.
- redirect_valid  in  1  load a new PC and flush.
- redirect_addr  in  WIDTH_ADDR  new PC.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  decode accepts the head.
- out_instr  out  WIDTH_DATA  head instruction.
- out_addr  out  WIDTH_ADDR  word address of the head instruction.

Behaviour:
- State:
  - pc.
  - inflight flag plus its address (a 1-deep request tag pipe).
  - FIFO storage, read pointer, write pointer and count (width log2(FIFO_DEPTH)+1).
- Reset:
  - pc=RESET_ADDR; inflight=0; count=0; pointers=0.
  - Outputs during and after rst: mem_re=0, out_valid=0. out_instr and out_addr are don't-care while out_valid=0.
- Issue:
  - mem_re = !rst && !redirect_valid && (count + inflight < FIFO_DEPTH).
  - The credit check deliberately excludes this cycle's pop, so there is no combinational path from out_ready to mem_re.
  - mem_addr = pc (combinational).
  - When mem_re=1: pc <= pc+1 modulo 2^WIDTH_ADDR (0xFFFF wraps to 0x0000), inflight <= 1, and the tag address <= pc. Otherwise inflight <= 0.
- Return:
  - When inflight=1, mem_data is written to the FIFO at the write pointer, together with the tag address.
  - mem_data is ignored whenever inflight=0.
- Credit guarantees that a push never hits a full FIFO. This is an assertion: no push when count==FIFO_DEPTH.
- Pop:
  - Occurs when out_valid && out_ready.
  - out_valid = (count != 0).
  - out_instr and out_addr come from registered FIFO storage at the read pointer, with no combinational path from mem_data.
  - Simultaneous push and pop leaves count unchanged.
- Latency and throughput:
  - First issue in the first cycle after rst deasserts (cycle 0).
  - Data is pushed at the end of cycle 1, and out_valid=1 in cycle 2.
  - With out_ready held high and FIFO_DEPTH >= 3: one instruction per cycle, steady-state count=1.
  - With FIFO_DEPTH=2: one instruction every 2 cycles (permitted, not an error).
- Redirect (redirect_valid=1 in cycle N):
  - mem_re=0 in cycle N.
  - pc <= redirect_addr.
  - inflight <= 0, so a read issued in N-1 is discarded on return.
  - count and pointers <= 0.
  - Any pop in cycle N is void: decode must treat a redirect as a kill of the head.
  - The first read of redirect_addr issues in N+1; out_valid=1 in N+3 at the earliest.
- Back-to-back redirects: the last one wins; each redirect cycle suppresses issue.
- Priority: rst > redirect_valid > issue/push/pop.
- Reset asserted mid-stream: the FIFO is emptied and the in-flight return is dropped. Behaviour is identical to a power-up reset.
- Stall (out_ready=0): the FIFO fills to FIFO_DEPTH, then mem_re=0. Issue resumes the cycle after a pop is registered (count drops).
- No combinational loops. All outputs except mem_re and mem_addr are register-driven.

Test Plan:
- Use a memory model with mem[a] = 0xA000_0000 + a and 1-cycle registered read.
- Reset, then out_ready=1 with RESET_ADDR=0: expect mem_re=1 in cycle 0, out_valid in cycle 2, then out_instr sequence 0xA0000000, 0xA0000001, … at one per cycle, with out_addr matching.
- out_ready=0 from reset with FIFO_DEPTH=4: expect count to reach 4 and mem_re to stay 0 afterwards. Raising out_ready yields addresses 0,1,2,3,4,… with no gap or duplicate.
- Redirect to 0x0100 in cycle 5 of streaming: expect mem_re=0 in cycle 5, out_valid=0 in cycles 6–7, out_addr=0x0100 with instr 0xA0000100 in cycle 8, and nothing from before the redirect appearing afterwards.
- Redirect to 0xFFFE: expect out_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001 with matching data.
- Redirect in the same cycle as out_valid && out_ready: expect the head discarded and the next output from redirect_addr. Back-to-back redirects to 0x10 then 0x20: expect first output 0x20.
- rst asserted for 1 cycle with the FIFO holding 3 entries and a read in flight: expect out_valid=0 the next cycle and a restart from RESET_ADDR with no stale words.
